// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the pipelined priority encoder.
// The round-robin mode is enabled by defining PRIO_ENC_RR_EN.
package prio_enc_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 256;

   // Number of bits needed to hold any index 0..n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if (((n - 1) >> i) != 0) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority search: grants the first set bit of vec scanning
// downward from start and wrapping from 0 back to WIDTH-1.
module prio_enc_core
   import prio_enc_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int OUT_W = clog2(WIDTH)
)(
   input  logic [WIDTH-1:0] vec,
   input  logic [OUT_W-1:0] start,
   output logic [OUT_W-1:0] idx,
   output logic             none
);

   logic [2*WIDTH-1:0] dbl;
   logic [OUT_W:0]     shamt;
   logic [WIDTH-1:0]   window;
   logic [OUT_W-1:0]   hi;
   logic [OUT_W:0]     sum;

   // Rotate so that bit 'start' lands on the top of the window; the search
   // then reduces to a plain highest-set-bit scan.
   assign dbl    = {vec, vec};
   assign shamt  = {1'b0, start} + 1'b1;
   assign window = WIDTH'(dbl >> shamt);

   always_comb begin
      hi = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (window[i]) hi = OUT_W'(i);
      end
   end

   assign sum  = shamt + {1'b0, hi};
   assign none = ~|vec;

   // Map the window position back to a request id; empty vector yields 0.
   always_comb begin
      idx = '0;
      if (!none) begin
         if (sum >= (OUT_W + 1)'(WIDTH)) idx = OUT_W'(sum - (OUT_W + 1)'(WIDTH));
         else                            idx = OUT_W'(sum);
      end
   end

endmodule

// File: rtl/priority_encoder_pipe.sv
// Priority encoder behind a single valid/ready output register.
// Define PRIO_ENC_RR_EN for round-robin priority; otherwise bit WIDTH-1 wins.
module priority_encoder_pipe
   import prio_enc_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int OUT_W = clog2(WIDTH)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] y,
   output logic             none
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("priority_encoder_pipe: WIDTH out of range");
   end

   // Handshake: a beat moves on a port when its valid and ready are both high
   // on a rising edge. The producer holds valid/data until accepted; ready may
   // depend combinationally on the downstream ready (in_ready follows
   // out_ready so the register refills in the cycle it drains).
   logic             in_xfer;
   logic [OUT_W-1:0] start;
   logic [OUT_W-1:0] g;
   logic             g_none;

   assign in_ready = !out_valid || out_ready;
   assign in_xfer  = in_valid && in_ready;

   prio_enc_core #(.WIDTH(WIDTH)) u_core (
      .vec   (a),
      .start (start),
      .idx   (g),
      .none  (g_none)
   );

`ifdef PRIO_ENC_RR_EN
   logic [OUT_W-1:0] ptr;

   // Next search starts just below the last grant, wrapping 0 -> WIDTH-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= OUT_W'(WIDTH - 1);
      end else if (in_xfer && !g_none) begin
         ptr <= (g == '0) ? OUT_W'(WIDTH - 1) : g - 1'b1;
      end
   end

   assign start = ptr;
`else
   assign start = OUT_W'(WIDTH - 1);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y         <= '0;
         none      <= 1'b0;
      end else if (in_xfer) begin
         out_valid <= 1'b1;
         y         <= g;
         none      <= g_none;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   property p_hold;
      @(posedge clk) disable iff (!rst_n)
         (out_valid && !out_ready) |=> (out_valid && $stable(y) && $stable(none));
   endproperty
   a_hold: assert property (p_hold);

endmodule
